des_pad_packer: RTL

- Upstream feeder for the DES encryption block.
- Accepts a byte stream with valid/ready handshake and packs it big-endian into 64-bit plaintext blocks.
- Applies the selected block padding on the final block of each message, appending a full padding block where the scheme requires it.
- Drives `plain`/`plain_en` directly into the encryption block, with `plain_ready` backpressure.

---
 rtl/des_pkg.sv | 37 +++
 rtl/des_pad_fill.sv | 39 +++
 rtl/des_pad_packer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared definitions for the DES front-end: padding codes, mode codes, block geometry,
// packer state encoding and the ISO10126 random-fill LFSR step.
package des_pkg;

    localparam int unsigned BLK_W     = 64;
    localparam int unsigned BLK_BYTES = 8;

    localparam logic [2:0] PAD_NONE     = 3'd0;
    localparam logic [2:0] PAD_ZEROS    = 3'd1;
    localparam logic [2:0] PAD_PKCS7    = 3'd2;
    localparam logic [2:0] PAD_ANSIX923 = 3'd3;
    localparam logic [2:0] PAD_ISO10126 = 3'd4;
    localparam logic [2:0] PAD_ONEZERO  = 3'd5;

    localparam logic MODE_ENCRYPT = 1'b0;
    localparam logic MODE_DECRYPT = 1'b1;

    // Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_OUT   = 2'd1,
        S_EXTRA = 2'd2
    } state_t;

    // Eight LFSR steps: one random byte's worth of advance.
    function automatic logic [31:0] lfsr_byte_step(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int unsigned k = 0; k < 8; k++) begin
            t = t[0] ? ((t >> 1) ^ LFSR_TAPS) : (t >> 1);
        end
        return t;
    endfunction

endpackage

// File: rtl/des_pad_fill.sv
// Combinational tail builder: keeps the first n bytes of the accumulator and fills the
// remaining 8-n bytes according to the padding scheme (n=0 yields a full pad block).
module des_pad_fill
    import des_pkg::*;
(
    input  logic [BLK_W-1:0] i_acc,
    input  logic [3:0]       i_n,
    input  logic [2:0]       i_scheme,
    input  logic [BLK_W-1:0] i_rnd,
    output logic [BLK_W-1:0] o_block
);

    logic [3:0] w_p;
    assign w_p = 4'd8 - i_n;

    always_comb begin
        logic [7:0]  v_b;
        int unsigned v_j;
        o_block = '0;
        for (int unsigned i = 0; i < BLK_BYTES; i++) begin
            v_j = i - 32'(i_n);
            v_b = '0;
            if (i < 32'(i_n)) begin
                v_b = i_acc[8*(7-i) +: 8];
            end else begin
                // v_j is the position within the pad run; i==7 is the final pad byte
                case (i_scheme)
                    PAD_PKCS7:    v_b = {4'd0, w_p};
                    PAD_ANSIX923: v_b = (i == 7) ? {4'd0, w_p} : 8'h00;
                    PAD_ISO10126: v_b = (i == 7) ? {4'd0, w_p} : i_rnd[8*v_j[2:0] +: 8];
                    PAD_ONEZERO:  v_b = (v_j == 0) ? 8'h80 : 8'h00;
                    default:      v_b = 8'h00;
                endcase
            end
            o_block[8*(7-i) +: 8] = v_b;
        end
    end

endmodule

// File: rtl/des_pad_packer.sv
// Byte-stream to 64-bit block packer with message padding, feeding the DES encryptor.
// Optional macro DES_PAD_ISO10126_EN enables LFSR random fill for ISO10126 padding.
module des_pad_packer
    import des_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    input  logic [2:0]       padding,
    output logic [BLK_W-1:0] plain,
    output logic             plain_en,
    input  logic             plain_ready,
    output logic             msg_done,
    output logic             pad_err
);

    if (LFSR_SEED == 32'd0) begin : g_bad_seed
        $error("LFSR_SEED must be non-zero");
    end

    state_t           r_state, w_next;
    logic [2:0]       r_cnt;
    logic [BLK_W-1:0] r_acc, r_plain;
    logic [2:0]       r_pad;
    logic             r_open, r_live, r_last, r_extra, r_pad_err;

    logic             w_accept, w_first, w_code_ok, w_done_byte, w_need_extra;
    logic [2:0]       w_mapped, w_scheme;
    logic [3:0]       w_n, w_p;
    logic [BLK_W-1:0] w_acc_new, w_fill_src, w_fill, w_rnd;

    assign w_accept    = din_valid & din_ready;
    assign w_first     = (r_cnt == 3'd0) & ~r_open;
    assign w_code_ok   = (padding <= PAD_ONEZERO);
    assign w_mapped    = w_code_ok ? padding : PAD_ZEROS;
    assign w_scheme    = w_first ? w_mapped : r_pad;
    assign w_done_byte = w_accept & (din_last | (r_cnt == 3'd7));
    assign w_acc_new   = r_acc | ({din, 56'd0} >> {r_cnt, 3'b000});
    assign w_n         = (r_state == S_EXTRA) ? 4'd0 : ({1'b0, r_cnt} + 4'd1);
    assign w_p         = 4'd8 - w_n;
    assign w_fill_src  = (r_state == S_EXTRA) ? '0 : w_acc_new;
    assign w_need_extra = din_last && (w_p == 4'd0) &&
        (w_scheme inside {PAD_PKCS7, PAD_ANSIX923, PAD_ISO10126, PAD_ONEZERO});

    des_pad_fill u_fill (
        .i_acc    (w_fill_src),
        .i_n      (w_n),
        .i_scheme (w_scheme),
        .i_rnd    (w_rnd),
        .o_block  (w_fill)
    );

`ifdef DES_PAD_ISO10126_EN
    logic [31:0] r_lfsr;
    logic [31:0] w_st [0:8];
    logic        w_builds_pad;

    assign w_builds_pad = (r_state == S_EXTRA) || (w_accept && din_last && (w_p != 4'd0));

    // Random byte k comes from k+1 byte-steps; the state after p-1 steps is kept.
    always_comb begin
        logic [31:0] v_s;
        v_s     = r_lfsr;
        w_st[0] = r_lfsr;
        w_rnd   = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            v_s           = lfsr_byte_step(v_s);
            w_st[k+1]     = v_s;
            w_rnd[8*k +: 8] = v_s[7:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_builds_pad && (w_scheme == PAD_ISO10126)) begin
            r_lfsr <= w_st[w_p - 4'd1];
        end
    end
`else
    assign w_rnd = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        din_ready = 1'b0;
        plain_en  = 1'b0;
        msg_done  = 1'b0;
        case (r_state)
            S_FILL: begin
                din_ready = r_live;
                if (w_done_byte) w_next = S_OUT;
            end
            S_OUT: begin
                plain_en = 1'b1;
                if (plain_ready) begin
                    msg_done = r_last;
                    w_next   = r_extra ? S_EXTRA : S_FILL;
                end
            end
            S_EXTRA: w_next = S_OUT;
            default: w_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_plain   <= '0;
            r_pad     <= PAD_NONE;
            r_open    <= 1'b0;
            r_live    <= 1'b0;
            r_last    <= 1'b0;
            r_extra   <= 1'b0;
            r_pad_err <= 1'b0;
        end else begin
            r_live    <= 1'b1;
            r_pad_err <= 1'b0;
            if (w_accept) begin
                if (w_first) begin
                    r_pad     <= w_mapped;
                    r_open    <= 1'b1;
                    r_pad_err <= ~w_code_ok;
                end
                if (w_done_byte) begin
                    r_plain <= w_fill;
                    r_last  <= din_last & ~w_need_extra;
                    r_extra <= w_need_extra;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    if (din_last && (w_p != 4'd0) && (w_scheme == PAD_NONE)) r_pad_err <= 1'b1;
                end else begin
                    r_acc <= w_acc_new;
                    r_cnt <= r_cnt + 3'd1;
                end
            end
            if (r_state == S_EXTRA) begin
                r_plain <= w_fill;
                r_last  <= 1'b1;
                r_extra <= 1'b0;
            end
            if (msg_done) r_open <= 1'b0;
        end
    end

    assign plain   = r_plain;
    assign pad_err = r_pad_err;

endmodule
